// File: rtl/scalar_writeback_scoreboard_pkg.sv
// Shared types and helpers for the scalar register-bank writeback path.
// r15 is the PC and is never tracked or written here.
package scalar_rf_pkg;

  localparam int BITS = 32;
  localparam logic [3:0] REG_PC = 4'hF;
  localparam int NUM_REGS = 15;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    logic [BITS-1:0] data;
  } wb_entry_t;

  function automatic logic is_pc(input reg_idx_t idx);
    return idx == REG_PC;
  endfunction

  // One-hot over r0..r14; the PC index never matches any bit.
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic en, input reg_idx_t idx);
    logic [NUM_REGS-1:0] m;
    for (int i = 0; i < NUM_REGS; i++) begin
      m[i] = en & (idx == reg_idx_t'(i));
    end
    return m;
  endfunction

  function automatic logic pend_at(input logic [NUM_REGS-1:0] p, input reg_idx_t idx);
    return |(p & reg_bit(1'b1, idx));
  endfunction

endpackage

// File: rtl/scalar_writeback_scoreboard_wb_fifo.sv
// Small synchronous FIFO holding load completions that lost write-port arbitration.
// Push and pop may occur together; a push while full is only taken alongside a pop.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty  = (count_r == {CW{1'b0}});
  assign full   = (count_r == CW'(DEPTH));
  assign pop_s  = pop & ~empty;
  assign push_s = push & (~full | pop_s);
  assign dout   = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/scalar_writeback_scoreboard.sv
// Scoreboard for r0..r14: stalls decode on RAW/WAW hazards and merges ALU and
// load completions onto the bank's single registered write port.
module scalar_writeback_scoreboard #(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ISSUE_VALID,
  input  logic            ISSUE_USE1,
  input  logic            ISSUE_USE2,
  input  logic [3:0]      ISSUE_RS1,
  input  logic [3:0]      ISSUE_RS2,
  input  logic            ISSUE_WE,
  input  logic [3:0]      ISSUE_RD,
  output logic            STALL,
  input  logic            ALU_VALID,
  input  logic [3:0]      ALU_RD,
  input  logic [BITS-1:0] ALU_DATA,
  input  logic            MEM_VALID,
  input  logic [3:0]      MEM_RD,
  input  logic [BITS-1:0] MEM_DATA,
  output logic            MEM_READY,
  output logic            WE3,
  output logic [3:0]      A3,
  output logic [BITS-1:0] WD3,
  output logic            BUSY,
  output logic            ERR
);

  import scalar_rf_pkg::*;

  localparam int EW = 4 + BITS;

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic                we3_r;
  reg_idx_t            a3_r;
  logic [BITS-1:0]     wd3_r;
  logic                err_r;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [EW-1:0]       fifo_dout_s;
  reg_idx_t            head_rd_s;
  logic [BITS-1:0]     head_data_s;
  logic                push_s;
  logic                pop_s;
  logic                sel_s;
  reg_idx_t            sel_rd_s;
  logic [BITS-1:0]     sel_data_s;
  logic                alu_ok_s;
  logic                mem_acc_s;
  logic                mem_ok_s;
  logic                err_s;
  logic                issue_acc_s;

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({MEM_RD, MEM_DATA}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign {head_rd_s, head_data_s} = fifo_dout_s;

  assign STALL = ISSUE_VALID & ((ISSUE_USE1 & pend_at(pending_r, ISSUE_RS1)) |
                                (ISSUE_USE2 & pend_at(pending_r, ISSUE_RS2)) |
                                (ISSUE_WE   & pend_at(pending_r, ISSUE_RD)));
  assign issue_acc_s = ISSUE_VALID & ~STALL;
  assign MEM_READY   = ~fifo_full_s;
  assign BUSY        = |pending_r;
  assign WE3         = we3_r;
  assign A3          = a3_r;
  assign WD3         = wd3_r;
  assign ERR         = err_r;

  assign alu_ok_s  = ALU_VALID & ~is_pc(ALU_RD);
  assign mem_acc_s = MEM_VALID & ~fifo_full_s;
  assign mem_ok_s  = mem_acc_s & ~is_pc(MEM_RD);

  // Write-port arbitration: ALU, then oldest buffered load, then direct load
  always_comb begin
    sel_s      = 1'b0;
    sel_rd_s   = 4'h0;
    sel_data_s = {BITS{1'b0}};
    push_s     = 1'b0;
    pop_s      = 1'b0;
    if (alu_ok_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = ALU_RD;
      sel_data_s = ALU_DATA;
      push_s     = mem_ok_s;
    end else if (!fifo_empty_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = head_rd_s;
      sel_data_s = head_data_s;
      pop_s      = 1'b1;
      push_s     = mem_ok_s;
    end else if (mem_ok_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = MEM_RD;
      sel_data_s = MEM_DATA;
    end else begin
      sel_s      = 1'b0;
    end
  end

  // A completion is legal only into a tracked register; the write in flight still counts as pending.
  assign err_s = (MEM_VALID & fifo_full_s) |
                 (ALU_VALID & (is_pc(ALU_RD) | ~pend_at(pending_r, ALU_RD))) |
                 (mem_acc_s & (is_pc(MEM_RD) | ~pend_at(pending_r, MEM_RD)));

  // Clear the register being written this cycle, then set the newly issued destination
  assign pend_nxt_s = (pending_r & ~reg_bit(we3_r, a3_r)) |
                      reg_bit(issue_acc_s & ISSUE_WE, ISSUE_RD);

  // Scoreboard, write port and sticky error state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_r <= {NUM_REGS{1'b0}};
      we3_r     <= 1'b0;
      a3_r      <= 4'h0;
      wd3_r     <= {BITS{1'b0}};
      err_r     <= 1'b0;
    end else begin
      pending_r <= pend_nxt_s;
      err_r     <= err_r | err_s;
      we3_r     <= sel_s;
      if (sel_s) begin
        a3_r  <= sel_rd_s;
        wd3_r <= sel_data_s;
      end
    end
  end

endmodule
